ccff_stream_loader: RTL and testbench

Configuration-chain loader that sits directly upstream of the logic-element fabric tiles. It accepts bitstream bytes over a valid/ready interface, serialises them LSB-first onto `ccff_head`, and asserts `ccff_shift_en` to gate the chain clock only when a bit is actually presented. It also captures the bits returned on `ccff_tail` into readback bytes, so software can verify the previous chain contents while loading new ones.

---
 rtl/ccff_stream_loader.sv | 142 ++++++++++++++
 tb/tb_ccff_stream_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_stream_loader.sv
// Configuration-chain loader: serialises bitstream bytes LSB-first onto the
// chain head, gates the chain clock per bit, and packs returned tail bits into readback bytes.
module ccff_stream_loader #(
  parameter int DATA_W    = 8,
  parameter int CHAIN_LEN = 80,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam int               BC_W        = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] DATA_W_C    = CNT_W'(DATA_W);
  localparam logic [BC_W-1:0]  RB_LAST     = BC_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [BC_W-1:0]   buf_cnt_q, buf_cnt_d;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d;
  logic [DATA_W-1:0] rb_acc_q, rb_acc_d;
  logic [BC_W-1:0]   rb_idx_q, rb_idx_d;
  logic [DATA_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;

  logic [CNT_W-1:0]  remaining;
  logic [DATA_W-1:0] rb_acc_next;
  logic              last_bit;

  assign remaining   = CHAIN_LEN_C - bit_count_q;
  assign last_bit    = (bit_count_q + CNT_W'(1)) == CHAIN_LEN_C;
  assign rb_acc_next = rb_acc_q | (DATA_W'(ccff_tail) << rb_idx_q);

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) state_d = SHIFT;
        SHIFT:      if (ccff_shift_en && last_bit) state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // Abort masks the shift enable so the chain and bit_count never disagree.
  always_comb begin
    busy          = (state_q == SHIFT);
    done          = (state_q == DONE);
    ccff_shift_en = busy && (buf_cnt_q != '0) && !abort;
    ccff_head     = ccff_shift_en & buf_q[0];
    in_ready      = busy && (buf_cnt_q == '0) && (bit_count_q < CHAIN_LEN_C);
  end

  always_comb begin
    buf_d       = buf_q;
    buf_cnt_d   = buf_cnt_q;
    bit_count_d = bit_count_q;
    rb_acc_d    = rb_acc_q;
    rb_idx_d    = rb_idx_q;
    rb_data_d   = rb_data_q;
    rb_valid_d  = 1'b0;

    if (abort) begin
      buf_d     = '0;
      buf_cnt_d = '0;
      rb_acc_d  = '0;
      rb_idx_d  = '0;
    end else if (start && (state_q != SHIFT)) begin
      buf_d       = '0;
      buf_cnt_d   = '0;
      bit_count_d = '0;
      rb_acc_d    = '0;
      rb_idx_d    = '0;
    end else if (ccff_shift_en) begin
      buf_d       = buf_q >> 1;
      buf_cnt_d   = buf_cnt_q - BC_W'(1);
      bit_count_d = bit_count_q + CNT_W'(1);
      if ((rb_idx_q == RB_LAST) || last_bit) begin
        rb_data_d  = rb_acc_next;
        rb_valid_d = 1'b1;
        rb_acc_d   = '0;
        rb_idx_d   = '0;
      end else begin
        rb_acc_d = rb_acc_next;
        rb_idx_d = rb_idx_q + BC_W'(1);
      end
    end else if (in_valid && in_ready) begin
      // The final byte only carries the bits the chain still needs.
      buf_d     = in_data;
      buf_cnt_d = (remaining >= DATA_W_C) ? BC_W'(DATA_W) : remaining[BC_W-1:0];
    end
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      buf_q       <= '0;
      buf_cnt_q   <= '0;
      bit_count_q <= '0;
      rb_acc_q    <= '0;
      rb_idx_q    <= '0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      buf_cnt_q   <= buf_cnt_d;
      bit_count_q <= bit_count_d;
      rb_acc_q    <= rb_acc_d;
      rb_idx_q    <= rb_idx_d;
      rb_data_q   <= rb_data_d;
      rb_valid_q  <= rb_valid_d;
    end
  end

  assign rb_data   = rb_data_q;
  assign rb_valid  = rb_valid_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Scoreboard bench for ccff_stream_loader: expected head bits and readback bytes are
// queued when a load is primed and popped as the chain shifts and readback strobes.
module tb_ccff_stream_loader;

  localparam int DATA_W    = 8;
  localparam int CHAIN_LEN = 12;
  localparam int CNT_W     = 16;

  logic              prog_clk = 1'b0;
  logic              pReset   = 1'b0;
  logic              start    = 1'b0;
  logic              abort    = 1'b0;
  logic              in_valid = 1'b0;
  logic              ccff_tail = 1'b0;
  logic [DATA_W-1:0] in_data  = '0;
  logic              in_ready, ccff_head, ccff_shift_en, rb_valid, busy, done;
  logic [DATA_W-1:0] rb_data;
  logic [CNT_W-1:0]  bit_count;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  int shift_cnt = 0;

  bit         head_q[$];
  bit         tail_q[$];
  logic [7:0] rb_q[$];

  logic [7:0] load_bytes [2] = '{8'hA5, 8'h03};
  logic [7:0] tail_bytes [2] = '{8'h3C, 8'h0F};

  ccff_stream_loader #(.DATA_W(DATA_W), .CHAIN_LEN(CHAIN_LEN), .CNT_W(CNT_W)) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start),
    .abort         (abort),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .rb_data       (rb_data),
    .rb_valid      (rb_valid),
    .busy          (busy),
    .done          (done),
    .bit_count     (bit_count)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Queue the head bits, the tail bits the fake chain returns, and the readback bytes.
  task automatic prime_model();
    logic [7:0] hb, tb, acc;
    int n;
    acc = '0;
    n = 0;
    shift_cnt = 0;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      hb = load_bytes[i / 8];
      tb = tail_bytes[i / 8];
      head_q.push_back(hb[i % 8]);
      tail_q.push_back(tb[i % 8]);
      acc[n] = tb[i % 8];
      n++;
      if (n == 8 || i == CHAIN_LEN - 1) begin
        rb_q.push_back(acc);
        acc = '0;
        n = 0;
      end
    end
  endtask

  always @(negedge prog_clk) begin
    if (mon_en) begin
      if (ccff_shift_en) begin
        shift_cnt++;
        if (head_q.size() > 0) check("head_bit", ccff_head, head_q.pop_front());
        else check("shift_beyond_chain", ccff_shift_en, 1'b0);
        ccff_tail = (tail_q.size() > 0) ? tail_q.pop_front() : 1'b0;
      end
      if (rb_valid) begin
        if (rb_q.size() > 0) check("rb_data", rb_data, rb_q.pop_front());
        else check("rb_unexpected", rb_valid, 1'b0);
      end
    end else begin
      ccff_tail = 1'b1;
    end
  end

  task automatic run_load(input int stall, output int cyc, output bit extra_ready);
    int idx, stall_left;
    bit acc;
    idx = 0;
    stall_left = stall;
    extra_ready = 1'b0;
    cyc = 0;
    @(negedge prog_clk); start = 1'b1;
    @(negedge prog_clk); start = 1'b0;
    in_valid = 1'b1;
    in_data  = load_bytes[0];
    while (!done && cyc < 100) begin
      if (idx == 1 && !in_valid && in_ready) begin
        if (stall_left > 0) begin
          check("stall_shift_en", ccff_shift_en, 1'b0);
          check("stall_head", ccff_head, 1'b0);
          check("stall_bit_count", bit_count, 8);
          stall_left--;
        end else begin
          in_valid = 1'b1;
          in_data  = load_bytes[1];
        end
      end
      acc = in_valid && in_ready;
      @(negedge prog_clk);
      cyc++;
      if (acc) begin
        idx++;
        if (idx == 1 && stall == 0) in_data = load_bytes[1];
        else if (idx == 1)          in_valid = 1'b0;
        else                        in_data = 8'hFF;
      end
      if (idx >= 2 && in_ready) extra_ready = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_in_ready"}, in_ready, 1'b0);
    check({pfx, "_head"}, ccff_head, 1'b0);
    check({pfx, "_shift_en"}, ccff_shift_en, 1'b0);
    check({pfx, "_rb_data"}, rb_data, 8'h00);
    check({pfx, "_rb_valid"}, rb_valid, 1'b0);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_done"}, done, 1'b0);
    check({pfx, "_bit_count"}, bit_count, 0);
  endtask

  initial begin
    int cyc, n;
    bit extra;

    #3;
    check_reset_outputs("reset");
    @(negedge prog_clk); pReset = 1'b1;

    // Basic load with readback, in_valid held high throughout.
    prime_model();
    mon_en = 1'b1;
    run_load(0, cyc, extra);
    @(negedge prog_clk);
    check("done_latency", cyc, CHAIN_LEN + 2);
    check("shift_count", shift_cnt, CHAIN_LEN);
    check("ready_after_last", extra, 1'b0);
    check("head_left", head_q.size(), 0);
    check("rb_left", rb_q.size(), 0);
    check("done_level", done, 1'b1);

    // start and abort together in DONE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    abort = 1'b0;
    check("collide_done", done, 1'b0);
    check("collide_busy", busy, 1'b0);
    check("collide_bit_count", bit_count, CHAIN_LEN);

    // Stalled load: same chain contents, five extra cycles.
    prime_model();
    run_load(5, cyc, extra);
    @(negedge prog_clk);
    check("stall_done_latency", cyc, CHAIN_LEN + 2 + 5);
    check("stall_shift_count", shift_cnt, CHAIN_LEN);
    check("stall_head_left", head_q.size(), 0);
    check("stall_rb_left", rb_q.size(), 0);

    // Abort after five shifted bits.
    mon_en = 1'b0;
    @(negedge prog_clk); start = 1'b1;
    @(negedge prog_clk); start = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    n = 0;
    while (bit_count != 5 && n < 40) begin
      @(negedge prog_clk);
      n++;
    end
    check("abort_reach_5", bit_count, 5);
    abort = 1'b1;
    in_valid = 1'b0;
    @(negedge prog_clk);
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_bit_count", bit_count, 5);
    check("abort_rb_valid", rb_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b0);
    check("abort_shift_en", ccff_shift_en, 1'b0);
    @(negedge prog_clk);
    check("abort_rb_valid_later", rb_valid, 1'b0);
    check("abort_bit_count_hold", bit_count, 5);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    check("restart_bit_count", bit_count, 0);
    check("restart_busy", busy, 1'b1);

    // Asynchronous reset while shifting.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    n = 0;
    while (bit_count != 3 && n < 40) begin
      @(negedge prog_clk);
      n++;
    end
    check("arst_reach_3", bit_count, 3);
    check("arst_pre_shift_en", ccff_shift_en, 1'b1);
    #1;
    pReset = 1'b0;
    #1;
    check_reset_outputs("arst");
    in_valid = 1'b0;
    @(negedge prog_clk);
    pReset = 1'b1;
    @(negedge prog_clk);
    check("post_reset_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
